// File: rtl/clk_div_monitor.sv
// Receive-side checker for divided clocks: measures period/high time of div_in in clk cycles,
// tracks lock against EXP_PERIOD and flags loss-of-clock. Optional input synchronizer: CLK_DIV_MON_SYNC_EN.
module clk_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 3,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             err,
    output logic             timeout
);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] LOCK   = 2'd2;

    localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);

    logic             div_s;
    logic             div_d;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [3:0]       match_cnt;
    logic [3:0]       match_nxt;
    logic [1:0]       state;

`ifdef CLK_DIV_MON_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= 2'b00;
        else       sync <= {sync[0], div_in};
    end

    assign div_s = sync[1];
`else
    assign div_s = div_in;
`endif

    assign rise      = div_s & ~div_d;
    assign match_nxt = match_cnt + 4'd1;

    // Both counters restart at 1 on a rise so the rise cycle itself is counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_d <= 1'b0;
            cnt   <= '0;
            hcnt  <= '0;
        end else begin
            div_d <= div_s;
            if (rise) begin
                cnt  <= ONE;
                hcnt <= ONE;
            end else begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + ONE;
                if (div_s && (hcnt != CNT_MAX))
                    hcnt <= hcnt + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SEARCH;
            match_cnt    <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            err          <= 1'b0;
            case (state)
                SEARCH: begin
                    if (rise) begin
                        state   <= TRACK;
                        timeout <= 1'b0;
                    end
                end
                TRACK, LOCK: begin
                    // A rise coinciding with cnt==TIMEOUT is measured, not timed out.
                    if (rise) begin
                        period       <= cnt;
                        high_time    <= hcnt;
                        period_valid <= 1'b1;
                        if (cnt == EXP_C) begin
                            if (state == TRACK) begin
                                match_cnt <= match_nxt;
                                if (match_nxt == LOCK_C) begin
                                    state  <= LOCK;
                                    locked <= 1'b1;
                                end
                            end
                        end else begin
                            err       <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                            state     <= TRACK;
                        end
                    end else if (cnt == TO_C) begin
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        state     <= SEARCH;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
Receive-side checker for divided clocks produced by the team's clock dividers (divide-by-3, divide-by-4). Samples the divided clock in the source clock domain, detects rising edges, and measures period and high time in clk cycles. Compares each period against an expected ratio and reports lock, mismatch and loss-of-clock. Sits beside each divider instance as a built-in self-check and a debug/status source.

Parameters:
CNT_W, 8, width of the period, high-time and cycle counters.
EXP_PERIOD, 3, expected divided-clock period in clk cycles; legal range 2 to 2^CNT_W-2.
LOCK_CNT, 4, consecutive matching periods required before locked asserts; legal range 1 to 15.
TIMEOUT, 32, cycles without a rising edge before loss-of-clock; EXP_PERIOD < TIMEOUT <= 2^CNT_W-1.

Ports:
clk  input  1  source clock; all logic on posedge.
reset  input  1  asynchronous, active-high; clears all state.
div_in  input  1  divided clock under test.
period  output  CNT_W  last measured rise-to-rise distance in clk cycles.
high_time  output  CNT_W  cycles div_s was sampled high within the last measured period.
period_valid  output  1  one-cycle pulse when period and high_time update.
locked  output  1  level; ratio confirmed.
err  output  1  one-cycle pulse on a period mismatch.
timeout  output  1  level; no rising edge for TIMEOUT cycles.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high, port named reset.
- Reset values: all outputs 0; cnt=0, hcnt=0, match_cnt=0, div_d=0; state=SEARCH.
- div_s is div_in, registered through the optional synchronizer when that feature is compiled in.
- rise = div_s & ~div_d, where div_d is div_s delayed by one clk.
- cnt:
  - On rise, cnt<=1.
  - Otherwise cnt<=cnt+1, saturating at 2^CNT_W-1.
  - On a rise, the measured distance is the current cnt.
- hcnt:
  - On rise, hcnt<=1.
  - Otherwise hcnt<=hcnt+div_s, saturating.
- States:
  - SEARCH: waiting for a first edge. On rise, go to TRACK and start counting. No period_valid, err or match update.
  - TRACK:
    - On rise: period<=cnt, high_time<=hcnt, period_valid<=1.
    - If cnt==EXP_PERIOD: match_cnt<=match_cnt+1. When the incremented value equals LOCK_CNT, go to LOCK and set locked<=1.
    - Else: err<=1, match_cnt<=0.
  - LOCK:
    - On rise: period, high_time and period_valid update as in TRACK.
    - On a mismatch: err<=1, locked<=0, match_cnt<=0, go to TRACK.
- Timeout: in TRACK or LOCK, if cnt==TIMEOUT and rise=0:
  - timeout<=1, locked<=0, match_cnt<=0, go to SEARCH.
  - timeout stays high until the next rise; that rise clears it.
- Simultaneous rise with cnt==TIMEOUT: the rise wins. It is a normal measurement, and a mismatch, since TIMEOUT > EXP_PERIOD.
- Latency: outputs update at the clk edge that samples rise, so they are visible one cycle after div_s first reads high. The optional synchronizer adds 2 cycles.
- Stuck-high or stuck-low input: no rise occurs, so the block times out.
- Reset asserted mid-operation: immediate asynchronous return to reset values. A rise in the first cycle after release only arms the block (SEARCH).

Optional Feature:
CLK_DIV_MON_SYNC_EN:
- Defined: div_in passes through a 2-flop synchronizer, also reset to 0, before edge detection. Use this for asynchronous or differently phased div_in. All output latencies grow by 2 clk.
- Undefined: div_in is sampled directly and assumed synchronous to clk. There is no extra latency.

Test Plan:
1. Default parameters; ideal divide-by-3 input (high 2, low 1) after reset release -> period=3 and high_time=2 on every pulse; locked=1 after the 4th measured period; err never pulses.
2. Locked; one period stretched to 4 -> period=4, err pulses once, locked drops the same cycle; relock after 4 further good periods.
3. EXP_PERIOD=4 with a divide-by-4 input (high 2, low 2) -> period=4, high_time=2; lock after 4 periods.
4. Locked; div_in held low for 40 cycles -> timeout=1 and locked=0 exactly 32 cycles after the last rise; the next rise clears timeout and returns the block to TRACK without period_valid.
5. Reset asserted mid-period while locked -> all outputs 0 immediately, with no clk edge required. After release, the first rise gives no period_valid and the second gives period=3.
6. With CLK_DIV_MON_SYNC_EN defined, repeat scenario 1 -> identical values, each update 2 cycles later.
